multiplicador_8bits: RTL and testbench
======================================

Name: multiplicador_8bits

Overview:
Sequential 8x8 unsigned shift-and-add multiplier producing a 16-bit product. It is the stage that drives the team's 8-bit ripple-carry adder (somador): it presents the adder operands each cycle and registers its sum and carry-out. It uses a start/busy/done handshake toward the control logic upstream. One multiply takes 8 iteration cycles.

Parameters:
WIDTH, 8, operand width; fixed at 8 because the somador instance is 8-bit. Any other value is unsupported.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in state IDLE
a  input  8  multiplicand, captured when start is accepted
b  input  8  multiplier, captured when start is accepted
busy  output  1  high while state is CALC
done  output  1  one-cycle pulse, high while state is DONE
produto  output  16  product {P_hi, Q}; valid while done=1 and held until next accepted start

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE, P_hi=0x00, Q=0x00, M=0x00, count=0, busy=0, done=0, produto=0x0000.
- Reset has priority over every other input in every state. Reset mid-CALC aborts the operation, clears all registers, and no done pulse follows.
- Registers: M[7:0] (multiplicand), P_hi[7:0] (partial high half), Q[7:0] (multiplier/low half), count[2:0].
- Adder connection: somador a=P_hi, b=(Q[0] ? M : 0x00), cin=0. The result is sum[7:0] and cout.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If start=1 at an edge: M<=a, Q<=b, P_hi<=0, count<=0, state<=CALC.
  - Otherwise hold all registers. produto keeps its last value.
- CALC, each edge:
  - {P_hi, Q} <= {cout, sum, Q[7:1]}. This is a 17-bit right shift of {cout, sum, Q}; cout is not lost.
  - count<=count+1.
  - When count==7 at the edge, state<=DONE.
  - start is ignored during CALC; a and b may change freely without effect.
- DONE: done=1 for exactly one cycle, then state<=IDLE unconditionally. start is ignored in DONE.
- Latency: start sampled at edge E0; iterations on edges E1..E8; done=1 in the cycle after E8; IDLE after E9. The earliest next accepted start is at E9 + 1 edge, so the minimum issue interval is 10 cycles.
- Output timing: busy=1 exactly in the 8 cycles between E0 and E8. produto is driven combinationally from {P_hi, Q}, and the registers hold after DONE, so the value persists.
- Width rules:
  - Unsigned only.
  - Maximum product 0xFE01 fits in 16 bits.
  - The adder never overflows beyond cout, since P_hi + M <= 0x1FE.
- Boundaries:
  - a=0 or b=0 still takes the full 8 cycles; product=0.
  - Back-to-back requests: start held high continuously is accepted again in the first IDLE cycle after DONE.

Decomposition:
- Package multiplicador_pkg holds:
  - WIDTH=8 and PROD_WIDTH=16
  - state encoding: IDLE=2'b00, CALC=2'b01, DONE=2'b10; 2'b11 decodes to IDLE
  - ITER_LAST=3'd7
- Exactly one sub-module instance: the existing somador (8-bit ripple adder), cin tied to 0.
- No other sub-modules. The operand mux and shift register are local.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, release, start=0 for 5 cycles -> busy=0, done=0, produto=0x0000 throughout.
- Basic multiply: a=0x0F, b=0x0F, start pulse -> busy=1 for 8 cycles, done=1 for 1 cycle, produto=0x00E1 and held afterward.
- Carry path: a=0xFF, b=0xFF -> produto=0xFE01. a=0x80, b=0x02 -> produto=0x0100. Checks that cout is shifted in.
- Zero and identity: a=0x00, b=0xA5 -> 0x0000 after 8 cycles. a=0x01, b=0xA5 -> 0x00A5.
- Ignored start: start and b=0x02 toggled during CALC of a=0x03, b=0x07 -> result 0x0015, single done pulse. start held continuously -> second result issued exactly 10 cycles after the first.
- Reset mid-operation: reset=1 at the 4th CALC cycle of 0xFF*0xFF -> next cycle busy=0, produto=0x0000, and no done pulse. A subsequent 0x12*0x34 -> 0x03A8.

Source files
------------

// File: rtl/multiplicador_pkg.sv
// Shared widths, iteration bound and FSM encoding for the shift-and-add multiplier.
package multiplicador_pkg;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned PROD_WIDTH = 16;
  localparam int unsigned CNT_WIDTH  = 3;

  localparam logic [CNT_WIDTH-1:0] ITER_LAST = 3'd7;

  // 2'b11 is unused and falls back to IDLE wherever the state is decoded
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/somador.sv
// 8-bit ripple-carry adder; the multiplier feeds it one partial product per cycle.
module somador
  import multiplicador_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  // Bit-serial carry chain, one full adder per bit
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[WIDTH];
  end

endmodule

// File: rtl/multiplicador_8bits.sv
// Sequential 8x8 unsigned shift-and-add multiplier with start/busy/done handshake.
// Each CALC cycle adds M (gated by Q[0]) to P_hi and shifts {cout, sum, Q} right.
module multiplicador_8bits
  import multiplicador_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  busy,
  output logic                  done,
  output logic [PROD_WIDTH-1:0] produto
);

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     p_hi;
  logic [WIDTH-1:0]     q;
  logic [CNT_WIDTH-1:0] count;
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     sum;
  logic                 cout;

  assign add_b = q[0] ? m : '0;

  somador u_somador (
    .a    (p_hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? CALC : IDLE;
      CALC:    state_next = (count == ITER_LAST) ? DONE : CALC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture in IDLE, add-and-shift in CALC, hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      m     <= '0;
      p_hi  <= '0;
      q     <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            p_hi  <= '0;
            count <= '0;
          end
        end
        CALC: begin
          {p_hi, q} <= {cout, sum, q[WIDTH-1:1]};
          count     <= count + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign produto = {p_hi, q};

endmodule

// File: tb/tb_multiplicador_8bits.sv
// Self-checking bench: directed cases plus random operands against a plain a*b model.
module tb_multiplicador_8bits;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] produto;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = 0;

  multiplicador_8bits dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .produto (produto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One multiply from IDLE; toggle scrambles start/b during CALC,
  // keep leaves start asserted so the caller can issue back-to-back.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        input bit toggle, input bit keep);
    logic [15:0] exp_p;
    exp_p = 16'(x) * 16'(y);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("busy_calc", 32'(busy), 32'd1);
      check("done_calc", 32'(done), 32'd0);
      if (!keep) start = 1'b0;
      if (toggle) begin
        start = i[0];
        b     = 8'h02;
      end else if (!keep) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      tick();
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("produto", 32'(produto), 32'(exp_p));
    done_cyc = cyc;
    if (!keep) start = 1'b0;
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("produto_held", 32'(produto), 32'(exp_p));
  endtask

  initial begin
    int first_done;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset then idle
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_produto", 32'(produto), 32'd0);
    end

    // Directed cases: basic, carry path, zero, identity
    run_op(8'h0F, 8'h0F, 1'b0, 1'b0);
    check("basic_0f_0f", 32'(produto), 32'h00E1);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    check("carry_ff_ff", 32'(produto), 32'hFE01);
    run_op(8'h80, 8'h02, 1'b0, 1'b0);
    check("carry_80_02", 32'(produto), 32'h0100);
    run_op(8'h00, 8'hA5, 1'b0, 1'b0);
    check("zero_00_a5", 32'(produto), 32'h0000);
    run_op(8'h01, 8'hA5, 1'b0, 1'b0);
    check("ident_01_a5", 32'(produto), 32'h00A5);

    // start and b toggled during CALC must not disturb the result
    run_op(8'h03, 8'h07, 1'b1, 1'b0);
    check("ignored_start", 32'(produto), 32'h0015);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_extra_done", 32'(done), 32'd0);
    end

    // start held continuously: second done exactly 10 cycles after first
    run_op(8'h21, 8'h43, 1'b0, 1'b1);
    first_done = done_cyc;
    run_op(8'h9C, 8'h5E, 1'b0, 1'b0);
    check("b2b_interval", 32'(done_cyc - first_done), 32'd10);

    // Reset during the 4th CALC cycle aborts with no done pulse
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_produto", 32'(produto), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("abort_no_done", 32'(done), 32'd0);
      tick();
    end
    run_op(8'h12, 8'h34, 1'b0, 1'b0);
    check("after_abort", 32'(produto), 32'h03A8);

    // Random operands, including occasional extremes
    for (int k = 0; k < 40; k++) begin
      logic [7:0] x;
      logic [7:0] y;
      x = 8'($urandom);
      y = 8'($urandom);
      if (k % 10 == 3) x = 8'hFF;
      if (k % 10 == 7) y = 8'h00;
      run_op(x, y, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
